multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/control_decode.sv | 36 +++
 rtl/multicycle_control.sv | 94 +++++++++
 tb/tb_multicycle_control.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU mode codes, opcode constants and FSM encodings for the multicycle controller.
package cpu_pkg;
  localparam logic [2:0] ALU_MODE_ADD      = 3'd0;
  localparam logic [2:0] ALU_MODE_SHIFT    = 3'd1;
  localparam logic [2:0] ALU_MODE_NOT      = 3'd2;
  localparam logic [2:0] ALU_MODE_AND      = 3'd3;
  localparam logic [2:0] ALU_MODE_OR       = 3'd4;
  localparam logic [2:0] ALU_MODE_XOR      = 3'd5;
  localparam logic [2:0] ALU_MODE_BYPASS_A = 3'd6;
  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_ADDI   = 5'b00001;
  localparam logic [4:0] OP_SHIFT  = 5'b00010;
  localparam logic [4:0] OP_NOT    = 5'b01000;
  localparam logic [4:0] OP_AND    = 5'b01010;
  localparam logic [4:0] OP_OR     = 5'b01100;
  localparam logic [4:0] OP_XOR    = 5'b01110;
  localparam logic [4:0] OP_CPY    = 5'b10000;
  localparam logic [4:0] OP_CPYPC  = 5'b10001;
  localparam logic [4:0] OP_LB     = 5'b10010;
  localparam logic [4:0] OP_SB     = 5'b10011;
  localparam logic [4:0] OP_JMPADR = 5'b10100;
  localparam logic [4:0] OP_JMPREL = 5'b11000;
  localparam logic [4:0] OP_BLT    = 5'b11010;
  localparam logic [4:0] OP_BGE    = 5'b11011;
  localparam logic [4:0] OP_BEQ    = 5'b11100;
  localparam logic [4:0] OP_BNEQ   = 5'b11101;
  localparam logic [4:0] OP_HALT   = 5'b11111;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  // CL_ALU also covers cpy/cpypc: every instruction that retires through WB with the ALU result
  typedef enum logic [2:0] {CL_ALU, CL_LB, CL_SB, CL_JMP, CL_BR, CL_HALT} class_t;
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode decode into ALU controls, instruction class and illegal flag.
module control_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [2:0] alu_mode,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output class_t     op_class,
  output logic       illegal
);
  always_comb begin
    alu_mode = ALU_MODE_ADD;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    op_class = CL_ALU;
    illegal = 1'b0;
    casez (opcode)
      5'b0000?: alu_b_sel = opcode[0];
      5'b0001?: begin alu_mode = ALU_MODE_SHIFT; alu_b_sel = opcode[0]; end
      5'b0100?: begin alu_mode = ALU_MODE_NOT; alu_b_sel = opcode[0]; end
      5'b0101?: begin alu_mode = ALU_MODE_AND; alu_b_sel = opcode[0]; end
      5'b0110?: begin alu_mode = ALU_MODE_OR; alu_b_sel = opcode[0]; end
      5'b0111?: begin alu_mode = ALU_MODE_XOR; alu_b_sel = opcode[0]; end
      5'b10000: alu_mode = ALU_MODE_BYPASS_A;
      5'b10001: begin alu_mode = ALU_MODE_BYPASS_A; alu_a_sel = 1'b1; end
      5'b10010: begin alu_mode = ALU_MODE_BYPASS_A; op_class = CL_LB; end
      5'b10011: begin alu_mode = ALU_MODE_BYPASS_A; op_class = CL_SB; end
      5'b1010?: begin alu_mode = ALU_MODE_BYPASS_A; op_class = CL_JMP; end
      5'b11000: begin alu_a_sel = 1'b1; alu_b_sel = 1'b1; op_class = CL_JMP; end
      5'b1101?, 5'b1110?: begin alu_a_sel = 1'b1; alu_b_sel = 1'b1; op_class = CL_BR; end
      5'b11111: op_class = CL_HALT;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with memory wait timeout and sticky status.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter bit FETCH_HS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [4:0] opcode,
  input  logic       flag_lt,
  input  logic       flag_zero,
  input  logic       mem_ready,
  output logic [2:0] alu_mode,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       rf_write_en,
  output logic       rf_write_sel,
  output logic       mem_req,
  output logic       mem_write_en,
  output logic       mem_fetch,
  output logic       ir_write_en,
  output logic       pc_inc_en,
  output logic       pc_load_en,
  output logic       halted,
  output logic       illegal_op,
  output logic       bus_error
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_t state;
  logic [4:0] op_q;
  logic [CW-1:0] cnt;
  logic [2:0] d_mode;
  logic d_a, d_b, d_ill;
  class_t d_cls;
  // DECODE looks at the live opcode to catch reserved codes; afterwards only the captured copy matters
  control_decode u_dec (
    .opcode(state == S_DECODE ? opcode : op_q),
    .alu_mode(d_mode),
    .alu_a_sel(d_a),
    .alu_b_sel(d_b),
    .op_class(d_cls),
    .illegal(d_ill)
  );
  logic in_exec, waiting, tmo, taken;
  assign in_exec = state == S_EXEC || state == S_MEM || state == S_WB;
  assign waiting = (state == S_FETCH && FETCH_HS) || state == S_MEM;
  assign tmo = !mem_ready && cnt == CW'(MEM_TIMEOUT - 1);
  assign taken = op_q[2] ? flag_zero ^ op_q[0] : flag_lt ^ op_q[0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      op_q <= '0;
      cnt <= '0;
      illegal_op <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      cnt <= (waiting && !mem_ready) ? cnt + 1'b1 : '0;
      case (state)
        S_IDLE: if (run) state <= S_FETCH;
        S_FETCH:
          if (!FETCH_HS || mem_ready) state <= S_DECODE;
          else if (tmo) begin state <= S_HALT; bus_error <= 1'b1; end
        S_DECODE: begin
          op_q <= opcode;
          if (d_ill) begin state <= S_HALT; illegal_op <= 1'b1; end
          else state <= S_EXEC;
        end
        S_EXEC: state <= d_cls == CL_ALU ? S_WB : (d_cls == CL_LB || d_cls == CL_SB) ? S_MEM :
                         d_cls == CL_HALT ? S_HALT : S_FETCH;
        S_MEM:
          if (mem_ready) state <= d_cls == CL_LB ? S_WB : S_FETCH;
          else if (tmo) begin state <= S_HALT; bus_error <= 1'b1; end
        S_WB: state <= S_FETCH;
        S_HALT: if (run) begin state <= S_FETCH; illegal_op <= 1'b0; bus_error <= 1'b0; end
        default: state <= S_IDLE;
      endcase
    end
  end
  assign alu_mode = in_exec ? d_mode : ALU_MODE_ADD;
  assign alu_a_sel = in_exec && d_a;
  assign alu_b_sel = in_exec && d_b;
  assign mem_fetch = state == S_FETCH;
  assign mem_req = waiting;
  assign mem_write_en = state == S_MEM && d_cls == CL_SB;
  assign ir_write_en = state == S_FETCH && (!FETCH_HS || mem_ready);
  assign rf_write_en = state == S_WB;
  assign rf_write_sel = state == S_WB && d_cls == CL_LB;
  assign pc_load_en = state == S_EXEC && (d_cls == CL_JMP || (d_cls == CL_BR && taken));
  assign pc_inc_en = (state == S_EXEC && (d_cls == CL_HALT || (d_cls == CL_BR && !taken))) ||
                     (state == S_MEM && d_cls == CL_SB && mem_ready) || state == S_WB;
  assign halted = state == S_HALT;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction streams checked cycle by cycle against per-instruction expected traces.
module tb_multicycle_control;
  localparam int TMO = 4;
  localparam logic [2:0] M_ADD = 3'd0, M_SHIFT = 3'd1, M_NOT = 3'd2, M_AND = 3'd3, M_OR = 3'd4, M_XOR = 3'd5, M_BYP = 3'd6;
  localparam int K_ALU = 0, K_LB = 1, K_SB = 2, K_JMP = 3, K_BR = 4, K_HALT = 5, K_RSV = 6;
  typedef struct packed {
    logic [2:0] mode;
    logic a, b, rfw, rfs, req, mwe, mf, irw, inc, ld, hlt, ill, berr;
  } out_t;
  logic clk = 1'b0, rst = 1'b0, run = 1'b0, flag_lt = 1'b0, flag_zero = 1'b0, mem_ready = 1'b0;
  logic [4:0] opcode = '0;
  logic [2:0] alu_mode;
  logic alu_a_sel, alu_b_sel, rf_write_en, rf_write_sel, mem_req, mem_write_en, mem_fetch;
  logic ir_write_en, pc_inc_en, pc_load_en, halted, illegal_op, bus_error;
  out_t got;
  int total = 0, bad = 0;
  int ops[28] = '{0, 1, 2, 3, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21, 24, 26, 27, 28, 29, 31, 22, 23, 25, 30};
  multicycle_control #(.MEM_TIMEOUT(TMO), .FETCH_HS(1'b1)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .flag_lt(flag_lt), .flag_zero(flag_zero),
    .mem_ready(mem_ready), .alu_mode(alu_mode), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .rf_write_en(rf_write_en), .rf_write_sel(rf_write_sel), .mem_req(mem_req), .mem_write_en(mem_write_en),
    .mem_fetch(mem_fetch), .ir_write_en(ir_write_en), .pc_inc_en(pc_inc_en), .pc_load_en(pc_load_en),
    .halted(halted), .illegal_op(illegal_op), .bus_error(bus_error)
  );
  assign got = {alu_mode, alu_a_sel, alu_b_sel, rf_write_en, rf_write_sel, mem_req, mem_write_en, mem_fetch,
                ir_write_en, pc_inc_en, pc_load_en, halted, illegal_op, bus_error};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, obs, exp);
    end
  endtask
  task automatic step(input string tag, input out_t e);
    #1 chk(tag, 32'(got), 32'(e));
    @(negedge clk);
  endtask
  task automatic noise();
    run = 1'($urandom);
    mem_ready = 1'($urandom);
    flag_lt = 1'($urandom);
    flag_zero = 1'($urandom);
    opcode = 5'($urandom);
  endtask
  function automatic void spec(input int op, output logic [2:0] mode, output logic a, output logic b, output int kind);
    mode = M_ADD; a = 1'b0; b = 1'b0; kind = K_RSV;
    if (op < 16) begin
      b = (op % 2) == 1;
      kind = K_ALU;
      case (op / 2)
        0: mode = M_ADD;
        1: mode = M_SHIFT;
        4: mode = M_NOT;
        5: mode = M_AND;
        6: mode = M_OR;
        7: mode = M_XOR;
        default: kind = K_RSV;
      endcase
    end else if (op < 24) begin
      mode = M_BYP;
      case (op)
        16: kind = K_ALU;
        17: begin kind = K_ALU; a = 1'b1; end
        18: kind = K_LB;
        19: kind = K_SB;
        20, 21: kind = K_JMP;
        default: kind = K_RSV;
      endcase
    end else begin
      case (op)
        24: begin kind = K_JMP; a = 1'b1; b = 1'b1; end
        26, 27, 28, 29: begin kind = K_BR; a = 1'b1; b = 1'b1; end
        31: kind = K_HALT;
        default: kind = K_RSV;
      endcase
    end
  endfunction
  function automatic logic br_taken(input int op, input logic lt, input logic z);
    case (op)
      26: return lt;
      27: return !lt;
      28: return z;
      default: return !z;
    endcase
  endfunction
  // HALT: status visible until run=1, which returns to FETCH
  task automatic halt_seq(input logic ill, input logic berr);
    out_t e;
    e = '0; e.hlt = 1'b1; e.ill = ill; e.berr = berr;
    repeat ($urandom_range(0, 2)) begin noise(); run = 1'b0; step("halt_hold", e); end
    noise(); run = 1'b1; step("halt_run", e);
  endtask
  // Starts and ends at a FETCH cycle; negative arguments pick random values
  task automatic do_instr(input int opi, input int fw, input int mw, input int fl);
    out_t e;
    logic [2:0] mode;
    logic a, b;
    int kind, op, nfw, nmw;
    op = opi >= 0 ? opi : ops[$urandom_range(0, 27)];
    nfw = fw >= 0 ? fw : ($urandom_range(0, 11) == 0 ? TMO : $urandom_range(0, 2));
    nmw = mw >= 0 ? mw : ($urandom_range(0, 7) == 0 ? TMO : $urandom_range(0, 3));
    spec(op, mode, a, b, kind);
    e = '0; e.req = 1'b1; e.mf = 1'b1;
    for (int i = 0; i < nfw; i++) begin noise(); mem_ready = 1'b0; step("fetch_wait", e); end
    if (nfw >= TMO) begin halt_seq(1'b0, 1'b1); return; end
    noise(); mem_ready = 1'b1; e.irw = 1'b1; step("fetch", e);
    noise(); opcode = 5'(op); e = '0; step("decode", e);
    if (kind == K_RSV) begin halt_seq(1'b1, 1'b0); return; end
    noise();
    if (fl >= 0) begin flag_lt = fl[0]; flag_zero = fl[1]; end
    e = '0; e.mode = mode; e.a = a; e.b = b;
    if (kind == K_JMP) e.ld = 1'b1;
    if (kind == K_HALT) e.inc = 1'b1;
    if (kind == K_BR) begin
      if (br_taken(op, flag_lt, flag_zero)) e.ld = 1'b1;
      else e.inc = 1'b1;
    end
    step("exec", e);
    if (kind == K_HALT) begin halt_seq(1'b0, 1'b0); return; end
    if (kind == K_JMP || kind == K_BR) return;
    if (kind == K_LB || kind == K_SB) begin
      e = '0; e.mode = mode; e.req = 1'b1; e.mwe = kind == K_SB;
      for (int i = 0; i < nmw; i++) begin noise(); mem_ready = 1'b0; step("mem_wait", e); end
      if (nmw >= TMO) begin halt_seq(1'b0, 1'b1); return; end
      noise(); mem_ready = 1'b1; e.inc = kind == K_SB; step("mem_done", e);
      if (kind == K_SB) return;
    end
    noise();
    e = '0; e.mode = mode; e.a = a; e.b = b; e.rfw = 1'b1; e.rfs = kind == K_LB; e.inc = 1'b1;
    step("wb", e);
  endtask
  initial begin
    out_t e;
    rst = 1'b1;
    @(negedge clk);
    step("reset", '0);
    rst = 1'b0;
    repeat (3) begin noise(); run = 1'b0; step("idle_hold", '0); end
    noise(); run = 1'b1; step("idle_run", '0);
    do_instr(1, 0, 0, -1);
    do_instr(26, 0, 0, 1);
    do_instr(26, 0, 0, 0);
    do_instr(18, 0, 3, -1);
    do_instr(19, 0, TMO, -1);
    do_instr(30, 0, 0, -1);
    do_instr(-1, TMO, -1, -1);
    for (int n = 0; n < 400; n++) do_instr(-1, -1, -1, -1);
    noise(); mem_ready = 1'b1; e = '0; e.req = 1'b1; e.mf = 1'b1; e.irw = 1'b1; step("fetch", e);
    noise(); opcode = 5'd18; step("decode", '0);
    noise(); e = '0; e.mode = M_BYP; step("exec", e);
    noise(); mem_ready = 1'b0; e = '0; e.mode = M_BYP; e.req = 1'b1;
    #1 chk("rst_mem_pre", 32'(got), 32'(e));
    #1 rst = 1'b1;
    #1 chk("rst_async", 32'(got), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin noise(); run = 1'b0; step("rst_idle", '0); end
    noise(); run = 1'b1; step("rst_run", '0);
    noise(); mem_ready = 1'b0; e = '0; e.req = 1'b1; e.mf = 1'b1; step("rst_fetch", e);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
